// File: rtl/frame_sync_deframer_pkg.sv
// Shared constants, state type and helpers for the frame sync deframer.
package frame_sync_deframer_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned PACKET_SIZE = 192;
    localparam logic [BYTE_W-1:0] SYNC_WORD = 8'hFF;
    localparam int unsigned FIFO_DEPTH  = 4;

    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    // Hunt bit counter stops at 8 so a full sync window is remembered
    function automatic logic [3:0] sat_inc8(input logic [3:0] c);
        return (c == 4'd8) ? c : c + 4'd1;
    endfunction

endpackage

// File: rtl/frame_sync_deframer_byte_fifo.sv
// Small synchronous FIFO buffering payload bytes toward the downstream consumer.
module byte_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == (PTR_W + 1)'(DEPTH));
    assign empty = (count == '0);

    // A pop on an empty FIFO is ignored; a push to a full FIFO only lands if a pop frees a slot
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign data_out = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/frame_sync_deframer.sv
// Serial bit-stream deframer: hunts for the sync byte, then packs payload bits into a byte FIFO.
module frame_sync_deframer #(
    parameter int unsigned PACKET_SIZE = frame_sync_deframer_pkg::PACKET_SIZE,
    parameter logic [frame_sync_deframer_pkg::BYTE_W-1:0] SYNC_WORD = frame_sync_deframer_pkg::SYNC_WORD,
    parameter int unsigned FIFO_DEPTH  = frame_sync_deframer_pkg::FIFO_DEPTH
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic                                       bit_in,
    input  logic                                       bit_valid,
    output logic [frame_sync_deframer_pkg::BYTE_W-1:0] byte_out,
    output logic                                       byte_valid,
    input  logic                                       byte_ready,
    output logic                                       locked,
    output logic                                       packet_done,
    output logic                                       overflow
);

    import frame_sync_deframer_pkg::*;

    localparam int unsigned PAYLOAD_BITS = PACKET_SIZE - BYTE_W;
    localparam int unsigned PCW          = $clog2(PAYLOAD_BITS);

    state_t            state;
    logic [BYTE_W-1:0] sr;
    logic [3:0]        hunt_cnt;
    logic [BYTE_W-1:0] asm_byte;
    logic [2:0]        bit_pos;
    logic [PCW-1:0]    pay_cnt;

    logic [BYTE_W-1:0] sr_next;
    logic [3:0]        hunt_cnt_next;
    logic [BYTE_W-1:0] asm_next;
    logic              last_bit;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;

    assign sr_next       = {sr[BYTE_W-2:0], bit_in};
    assign hunt_cnt_next = sat_inc8(hunt_cnt);
    assign asm_next      = {asm_byte[BYTE_W-2:0], bit_in};
    assign last_bit      = (pay_cnt == PCW'(PAYLOAD_BITS - 1));

    assign push       = bit_valid && (state == PAYLOAD) && (bit_pos == 3'd7);
    assign byte_valid = !fifo_empty;
    assign pop        = byte_valid && byte_ready;
    assign locked     = (state == PAYLOAD);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= HUNT;
            sr          <= '0;
            hunt_cnt    <= '0;
            asm_byte    <= '0;
            bit_pos     <= '0;
            pay_cnt     <= '0;
            packet_done <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            packet_done <= 1'b0;
            if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
            if (bit_valid) begin
                case (state)
                    HUNT: begin
                        sr       <= sr_next;
                        hunt_cnt <= hunt_cnt_next;
                        if (sr_next == SYNC_WORD && hunt_cnt_next == 4'd8) begin
                            state    <= PAYLOAD;
                            asm_byte <= '0;
                            bit_pos  <= '0;
                            pay_cnt  <= '0;
                        end
                    end
                    PAYLOAD: begin
                        asm_byte <= asm_next;
                        bit_pos  <= bit_pos + 3'd1;
                        pay_cnt  <= pay_cnt + PCW'(1);
                        if (last_bit) begin
                            state       <= HUNT;
                            sr          <= '0;
                            hunt_cnt    <= '0;
                            pay_cnt     <= '0;
                            packet_done <= 1'b1;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    byte_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .data_in  (asm_next),
        .data_out (byte_out),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_frame_sync_deframer.sv
// Directed bench for frame_sync_deframer using the "This is a test message!" frame.
module tb_frame_sync_deframer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready = 1'b1;
    logic       locked;
    logic       packet_done;
    logic       overflow;

    int cmp_cnt = 0;
    int err_cnt = 0;

    logic [7:0] rx_q[$];
    int         pd_cnt = 0;
    int         lock_cycles = 0;

    logic [7:0] pay [23] = '{8'h54, 8'h68, 8'h69, 8'h73, 8'h20, 8'h69, 8'h73, 8'h20,
                             8'h61, 8'h20, 8'h74, 8'h65, 8'h73, 8'h74, 8'h20, 8'h6d,
                             8'h65, 8'h73, 8'h73, 8'h61, 8'h67, 8'h65, 8'h21};

    frame_sync_deframer dut (
        .clock       (clock),
        .reset       (reset),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .byte_out    (byte_out),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .locked      (locked),
        .packet_done (packet_done),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset && byte_valid && byte_ready) rx_q.push_back(byte_out);
        if (packet_done) pd_cnt++;
        if (locked) lock_cycles++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        @(posedge clock);
        #1;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int i = 7; i >= 0; i--) begin
            drive(b[i]);
            idle(gap);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        idle(n);
        reset = 1'b0;
    endtask

    // Full frame with checks on lock timing and the packet_done pulse
    task automatic run_frame(input int gap, input string tag);
        int pd_base;
        logic [7:0] last;
        pd_base = pd_cnt;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1);
            idle(gap);
        end
        chk({tag, "_lock_before_8th"}, locked, 1'b0);
        drive(1'b1);
        chk({tag, "_lock_after_8th"}, locked, 1'b1);
        idle(gap);
        for (int k = 0; k < 22; k++) send_byte(pay[k], gap);
        last = pay[22];
        for (int i = 7; i >= 1; i--) begin
            drive(last[i]);
            idle(gap);
        end
        chk({tag, "_no_early_done"}, pd_cnt - pd_base, 0);
        drive(last[0]);
        chk({tag, "_done_pulse"}, packet_done, 1'b1);
        chk({tag, "_unlock"}, locked, 1'b0);
        idle(1);
        chk({tag, "_done_one_cycle"}, packet_done, 1'b0);
        idle(gap + 4);
        chk({tag, "_done_count"}, pd_cnt - pd_base, 1);
    endtask

    task automatic check_bytes(input int base, input string tag);
        chk({tag, "_byte_count"}, rx_q.size() - base, 23);
        for (int i = 0; i < 23; i++) begin
            if (base + i < rx_q.size())
                chk($sformatf("%s_byte%0d", tag, i), rx_q[base + i], pay[i]);
        end
    endtask

    initial begin
        int base;
        int lk;

        // Reset state
        do_reset(2);
        chk("rst_byte_out", byte_out, 8'h00);
        chk("rst_byte_valid", byte_valid, 1'b0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_packet_done", packet_done, 1'b0);
        chk("rst_overflow", overflow, 1'b0);

        // Back-to-back bits, consumer always ready
        base = rx_q.size();
        run_frame(0, "basic");
        check_bytes(base, "basic");

        // Junk prefix before the sync byte
        base = rx_q.size();
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        chk("prefix_no_lock", locked, 1'b0);
        run_frame(0, "prefix");
        check_bytes(base, "prefix");

        // Sparse bit_valid, one cycle in four
        base = rx_q.size();
        run_frame(3, "sparse");
        check_bytes(base, "sparse");

        // Consumer stalled: FIFO fills, fifth byte is dropped
        byte_ready = 1'b0;
        base = rx_q.size();
        send_byte(8'hFF, 0);
        chk("ovf_locked", locked, 1'b1);
        for (int k = 0; k < 23; k++) begin
            send_byte(pay[k], 0);
            if (k == 3) chk("ovf_clear_at_4", overflow, 1'b0);
            if (k == 4) chk("ovf_set_at_5", overflow, 1'b1);
        end
        chk("ovf_frame_end", locked, 1'b0);
        byte_ready = 1'b1;
        idle(8);
        chk("ovf_drain_count", rx_q.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < rx_q.size())
                chk($sformatf("ovf_drain%0d", i), rx_q[base + i], pay[i]);
        end
        chk("ovf_drained_empty", byte_valid, 1'b0);
        chk("ovf_sticky", overflow, 1'b1);

        // Reset mid-frame with buffered bytes
        byte_ready = 1'b0;
        send_byte(8'hFF, 0);
        for (int k = 0; k < 5; k++) send_byte(pay[k], 0);
        chk("mid_buffered", byte_valid, 1'b1);
        do_reset(1);
        chk("mid_rst_valid", byte_valid, 1'b0);
        chk("mid_rst_locked", locked, 1'b0);
        chk("mid_rst_overflow", overflow, 1'b0);
        byte_ready = 1'b1;
        idle(2);
        base = rx_q.size();
        run_frame(0, "resend");
        check_bytes(base, "resend");

        // Reset clears the partial hunt window
        lk = lock_cycles;
        for (int i = 0; i < 7; i++) drive(1'b1);
        do_reset(1);
        drive(1'b1);
        send_byte(8'h00, 0);
        idle(4);
        chk("hunt_rst_no_lock", lock_cycles - lk, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/frame_sync_deframer.md
FRAME_SYNC_DEFRAMER -- requirements
Module: frame_sync_deframer

Interface
REQ-001 SHALL have parameter PACKET_SIZE, default 192, meaning total frame bits including sync byte.
REQ-002 SHALL have parameter SYNC_WORD, default 8'hFF, meaning frame sync byte, sent MSB first.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning output byte buffer entries (power of 2).
REQ-004 SHALL have port clock  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port bit_in  input  1  recovered data bit from the demodulating receiver.
REQ-007 SHALL have port bit_valid  input  1  bit_in is sampled only on cycles where this is high.
REQ-008 SHALL have port byte_out  output  8  head-of-FIFO payload byte.
REQ-009 SHALL have port byte_valid  output  1  high while the FIFO is non-empty.
REQ-010 SHALL have port byte_ready  input  1  downstream (UART transmitter) accepts byte_out.
REQ-011 SHALL have port locked  output  1  high while in PAYLOAD state.
REQ-012 SHALL have port packet_done  output  1  one-cycle pulse when a frame's last payload bit is taken.
REQ-013 SHALL have port overflow  output  1  sticky flag, set when a payload byte is dropped.

Function
REQ-014 SHALL implement two states: HUNT and PAYLOAD.
REQ-015 In HUNT, on each bit_valid cycle, SHALL shift sr <= {sr[6:0], bit_in} and increment a bit count saturating at 8.
REQ-016 SHALL enter PAYLOAD on the bit_valid cycle where the post-shift sr equals SYNC_WORD and the post-increment count is 8.
REQ-017 In PAYLOAD, SHALL assemble bits MSB first into a byte; on every 8th bit SHALL push the byte into the FIFO.
REQ-018 The pushed byte SHALL appear on byte_out/byte_valid the cycle after the 8th bit's bit_valid cycle when the FIFO was empty.
REQ-019 After PACKET_SIZE-8 payload bits (23 bytes at default), SHALL pulse packet_done for one cycle, return to HUNT, and clear sr and the bit count.
REQ-020 A byte SHALL be popped on every cycle with byte_valid and byte_ready both high.
REQ-021 Push to a full FIFO with no pop SHALL drop the byte and set overflow; the frame bit count SHALL continue.
REQ-022 Simultaneous push and pop when full SHALL accept the push.
REQ-023 Simultaneous push and pop when empty SHALL leave the FIFO holding the new byte; the pop SHALL be ignored because byte_valid was low.
REQ-024 Cycles with bit_valid low SHALL change no frame state; gaps of any length SHALL be tolerated.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be one bit wider than the pointers.
REQ-026 overflow SHALL clear only on reset.

Reset
REQ-027 On reset, SHALL enter state HUNT and clear sr, the bit count, the byte assembler and the FIFO.
REQ-028 On reset, outputs SHALL be byte_out=0, byte_valid=0, locked=0, packet_done=0 and overflow=0, effective the cycle after reset is sampled high.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame and all buffered bytes.

Structure
REQ-030 PACKET_SIZE, SYNC_WORD, the byte width (8) and the state enum SHALL live in the shared parameters package.
REQ-031 The FIFO SHALL be a sub-module named byte_fifo, with push/pop/full/empty/data ports and synchronous reset.
REQ-032 The deframer FSM, shift register and counters SHALL reside in frame_sync_deframer.

Verification
REQ-033 Stimulus: frame 0xFF546869732069732061207465737420 6d65737361676521, bit_valid=1 every cycle, byte_ready=1. Response: 23 bytes 0x54, 0x68, 0x69, 0x73 … 0x21; packet_done one cycle after the last bit; locked then falls.
REQ-034 Stimulus: prefix 0x00, 0xAA, then the REQ-033 frame. Response: locked rises only after the 8th bit of 0xFF; byte stream identical to REQ-033.
REQ-035 Stimulus: REQ-033 frame with bit_valid high one cycle in four. Response: identical bytes; no packet_done before the final bit.
REQ-036 Stimulus: REQ-033 frame with byte_ready=0 throughout, then byte_ready=1. Response: overflow=1 once the 5th byte arrives; then exactly 0x54, 0x68, 0x69, 0x73 are drained, then byte_valid=0.
REQ-037 Stimulus: reset pulsed after 5 payload bytes, then the full frame resent. Response: the cycle after reset, byte_valid=0 and locked=0; the resent frame yields all 23 correct bytes.
REQ-038 Stimulus: seven 1 bits, reset, one 1 bit, then 0x00. Response: locked never rises.
